serial_adder: RTL and testbench

Bit-serial add/subtract unit built around a single one-bit full-adder slice, with operands held in shift registers. Operands are loaded on `start`. One bit pair from each operand, plus the stored carry, goes through the slice per clock, LSB first. The N-bit result and ALU flags are assembled into registered outputs. It sits in the ALU experiment as the sequential consumer of the full-adder cell: the low-area alternative to the ripple-carry adder.

---
 rtl/serial_adder.sv | 149 ++++++++++++++
 tb/tb_serial_adder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder slice, LSB first, WIDTH+1 cycles per operation.
// Subtraction is only built when SERIAL_ADDER_SUB_EN is defined; otherwise `sub` is ignored.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   s_sh_q, s_sh_d;
    logic               c_q, c_d;
    logic               c_msb_in_q, c_msb_in_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               sub_eff;
    logic               s_bit;
    logic               c_next;
    logic [WIDTH-1:0]   sum_next;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign sub_eff    = 1'b0;
`endif

    // The single full-adder slice
    assign s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign c_next   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
    assign sum_next = {s_bit, s_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        s_sh_d     = s_sh_q;
        c_d        = c_q;
        c_msb_in_d = c_msb_in_q;
        cnt_d      = cnt_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        result_d   = result_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = sub_eff ? ~b : b;
                    c_d     = sub_eff;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                c_d    = c_next;
                s_sh_d = sum_next;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                busy_d = 1'b1;
                // MSB slice: capture carry-in for overflow and publish the result
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    c_msb_in_d = c_q;
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    result_d   = sum_next;
                    cout_d     = c_next;
                    ovf_d      = c_msb_in_d ^ c_next;
                    zero_d     = (sum_next == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            s_sh_q     <= '0;
            c_q        <= 1'b0;
            c_msb_in_q <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            s_sh_q     <= s_sh_d;
            c_q        <= c_d;
            c_msb_in_q <= c_msb_in_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus hold-start and mid-run reset sequences.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples each cycle at negedge until done; lat = sample index of done (0 = timeout)
    task automatic wait_done(output int lat, output int nbusy, output int overlap);
        lat = 0; nbusy = 0; overlap = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (busy && done) overlap++;
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat, nbusy, overlap, seen_done;

    initial begin
        vec[0] = '{8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0};
        vec[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vec[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vec[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vec[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
`ifdef SERIAL_ADDER_SUB_EN
        vec[5] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
        vec[6] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
        vec[7] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
`else
        vec[5] = '{8'h05, 8'h07, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0};
        vec[6] = '{8'h80, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
        vec[7] = '{8'h05, 8'h05, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0};
`endif

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   busy,   0);
        chk("rst_done",   done,   0);
        chk("rst_result", result, 0);
        chk("rst_cout",   cout,   0);
        chk("rst_ovf",    ovf,    0);
        chk("rst_zero",   zero,   0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            a = vec[i].a; b = vec[i].b; sub = vec[i].sub; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0; a = ~a; b = ~b;
            wait_done(lat, nbusy, overlap);
            chk($sformatf("v%0d_latency", i), lat,      9);
            chk($sformatf("v%0d_busy",    i), nbusy,    8);
            chk($sformatf("v%0d_overlap", i), overlap,  0);
            chk($sformatf("v%0d_result",  i), result,   vec[i].res);
            chk($sformatf("v%0d_cout",    i), cout,     vec[i].cout);
            chk($sformatf("v%0d_ovf",     i), ovf,      vec[i].ovf);
            chk($sformatf("v%0d_zero",    i), zero,     vec[i].zero);
        end
        @(negedge clk);
        chk("done_pulse_one_cycle", done, 0);

        // start held through RUN is ignored; still high in DONE starts the next op
        a = 8'h35; b = 8'h0A; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 a = 8'h01; b = 8'h02;
        wait_done(lat, nbusy, overlap);
        chk("hold_latency", lat,    9);
        chk("hold_result",  result, 8'h3F);
        @(negedge clk);
        chk("back2back_busy", busy, 1);
        chk("back2back_done", done, 0);
        wait_done(lat, nbusy, overlap);
        start = 1'b0;
        chk("back2back_latency", lat,    8);
        chk("back2back_result",  result, 8'h03);
        chk("back2back_overlap", overlap, 0);
        @(negedge clk);
        chk("after_b2b_busy", busy, 0);
        chk("after_b2b_done", done, 0);

        // reset during the 4th RUN cycle
        a = 8'h35; b = 8'h0A; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy",   busy,   0);
        chk("midrst_done",   done,   0);
        chk("midrst_result", result, 0);
        chk("midrst_cout",   cout,   0);
        rst = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        chk("midrst_no_activity", seen_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
